// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control slice.
//  - ALU_DATA_WIDTH / ALU_FUNC_WIDTH: default operand and func widths
//    shared with the ALU instance.
//  - state_t: alu_arbiter sequencing states.
//  - onehot2: index-to-one-hot helper for two-way arbiters.
package alu_ctrl_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 32;
  localparam int unsigned ALU_FUNC_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//  reqValid  in  2  request lines (bit i = requester i)
//  lastGrant in  1  index of the most recent winner
//  grant     out 2  one-hot grant, zero when nothing requests
//  grantIdx  out 1  index of the winner (0 when nothing requests)
//  grantAny  out 1  at least one request present
module rr_arbiter2
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] reqValid,
  input  logic       lastGrant,
  output logic [1:0] grant,
  output logic       grantIdx,
  output logic       grantAny
);

  always_comb begin
    grantIdx = 1'b0;
    case (reqValid)
      2'b01:   grantIdx = 1'b0;
      2'b10:   grantIdx = 1'b1;
      // Contention: the requester that did not win last time goes next.
      2'b11:   grantIdx = ~lastGrant;
      default: grantIdx = 1'b0;
    endcase
    grantAny = |reqValid;
    grant    = grantAny ? onehot2(grantIdx) : 2'b00;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with valid/ready handshakes and
// round-robin arbitration. The winner's operands are latched into the
// alu_* registers, the ALU evaluates for one cycle, and its result is
// registered and returned with the owning requester's index.
// Ports:
//  clk, reset                  clock (rising edge), async active-high reset
//  req_valid/req_ready [1:0]   per-requester request handshake
//  req_alt/func/a/b            per-requester operands, req i in slice i
//  rsp_valid/rsp_ready         result handshake
//  rsp_id, rsp_data, rsp_cmp   result owner, registered dataOut / beqOut
//  alu_alt_op/func/data1/data2 registered operands to the ALU
//  alu_data_out, alu_cmp       ALU results
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned FUNC_WIDTH = ALU_FUNC_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_alt,
  input  logic [2*FUNC_WIDTH-1:0] req_func,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_cmp,
  output logic                    alu_alt_op,
  output logic [FUNC_WIDTH-1:0]   alu_func,
  output logic [DATA_WIDTH-1:0]   alu_data1,
  output logic [DATA_WIDTH-1:0]   alu_data2,
  input  logic [DATA_WIDTH-1:0]   alu_data_out,
  input  logic                    alu_cmp
);

  state_t state;
  logic   lastGrant;

  logic [1:0] grant;
  logic       grantIdx;
  logic       grantAny;
  logic       fire;

  logic                  selAlt;
  logic [FUNC_WIDTH-1:0] selFunc;
  logic [DATA_WIDTH-1:0] selA;
  logic [DATA_WIDTH-1:0] selB;

  rr_arbiter2 uArb (
    .reqValid (req_valid),
    .lastGrant(lastGrant),
    .grant    (grant),
    .grantIdx (grantIdx),
    .grantAny (grantAny)
  );

  // Grant is only offered in IDLE, and never while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (!reset && state == S_IDLE) req_ready = grant;
    fire = |(req_valid & req_ready);
  end

  always_comb begin
    selAlt  = grantIdx ? req_alt[1] : req_alt[0];
    selFunc = grantIdx ? req_func[FUNC_WIDTH +: FUNC_WIDTH] : req_func[0 +: FUNC_WIDTH];
    selA    = grantIdx ? req_a[DATA_WIDTH +: DATA_WIDTH]    : req_a[0 +: DATA_WIDTH];
    selB    = grantIdx ? req_b[DATA_WIDTH +: DATA_WIDTH]    : req_b[0 +: DATA_WIDTH];
  end

  // alu_* registers are only written on accept, so the ALU sees the last
  // latched operation in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lastGrant  <= 1'b1;
      alu_alt_op <= 1'b0;
      alu_func   <= '0;
      alu_data1  <= '0;
      alu_data2  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_cmp    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            alu_alt_op <= selAlt;
            alu_func   <= selFunc;
            alu_data1  <= selA;
            alu_data2  <= selB;
            rsp_id     <= grantIdx;
            lastGrant  <= grantIdx;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= alu_data_out;
          rsp_cmp   <= alu_cmp;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
